// File: rtl/pwm_duty_sched.sv
// -----------------------------------------------------------------------------
// pwm_duty_sched
//
// Sequences the 11-bit duty word of the PWM11 generator. Signed speed commands
// arrive over a valid/ready handshake and become an offset-binary target that
// is clamped to the range where PWM11 non-overlap arithmetic stays valid. The
// applied duty moves toward the target by at most SLEW_STEP per PWM period and
// only changes on PWM_synch. Unblanked over-current seen in FAULT_LIMIT
// consecutive periods latches a fault that parks the bridge at 50% duty.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   en           drive enable
//   cmd_vld      speed command valid
//   cmd_rdy      block can accept a command (low only while faulted)
//   cmd_spd      signed speed command, -1024..+1023
//   PWM_synch    one-cycle pulse from PWM11 at counter zero
//   ovr_I_blank  PWM11 over-current blanking window
//   ovr_I        raw over-current comparator
//   clr_fault    fault clear request (honoured only with en low)
//   duty         duty word to PWM11
//   fault        latched over-current fault
//   at_tgt       duty equals target while running
// -----------------------------------------------------------------------------
module pwm_duty_sched #(
  parameter logic [10:0] SLEW_STEP   = 11'd16,
  parameter logic [10:0] MIN_DUTY    = 11'h040,
  parameter logic [10:0] MAX_DUTY    = 11'h7BF,
  parameter logic [2:0]  FAULT_LIMIT = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [10:0] cmd_spd,
  input  logic        PWM_synch,
  input  logic        ovr_I_blank,
  input  logic        ovr_I,
  input  logic        clr_fault,
  output logic [10:0] duty,
  output logic        fault,
  output logic        at_tgt
);

  localparam logic [10:0] MID_DUTY = 11'h400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RAMP_DN,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] duty_q, duty_d;
  logic [10:0] target_q, target_d;
  logic        fault_q, fault_d;
  logic [2:0]  fault_cnt_q, fault_cnt_d;
  logic        oc_seen_q, oc_seen_d;
  logic        at_tgt_q, at_tgt_d;

  logic        oc_now;
  logic        oc_per;
  logic [2:0]  cnt_inc;
  logic        trip;

  // Speed to offset binary: flipping the sign bit adds 0x400.
  function automatic logic [10:0] clamp_duty(input logic [10:0] spd);
    logic [10:0] ofs;
    ofs = {~spd[10], spd[9:0]};
    if (ofs < MIN_DUTY)      return MIN_DUTY;
    else if (ofs > MAX_DUTY) return MAX_DUTY;
    else                     return ofs;
  endfunction

  // One slew step toward goal; 12-bit intermediates so neither direction wraps.
  function automatic logic [10:0] slew_toward(input logic [10:0] cur,
                                              input logic [10:0] goal);
    logic [11:0] up;
    logic [11:0] dn;
    up = {1'b0, cur} + {1'b0, SLEW_STEP};
    dn = {1'b0, cur} - {1'b0, SLEW_STEP};
    if (cur < goal)      return (up > {1'b0, goal}) ? goal : up[10:0];
    else if (cur > goal) return (dn[11] || (dn < {1'b0, goal})) ? goal : dn[10:0];
    else                 return cur;
  endfunction

  assign cmd_rdy = (state_q != S_FAULT);
  assign oc_now  = ovr_I && !ovr_I_blank;
  assign oc_per  = oc_seen_q || oc_now;
  assign cnt_inc = (fault_cnt_q == 3'd7) ? 3'd7 : fault_cnt_q + 3'd1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    duty_d      = duty_q;
    target_d    = target_q;
    fault_d     = fault_q;
    fault_cnt_d = fault_cnt_q;
    oc_seen_d   = oc_seen_q;
    trip        = 1'b0;

    // Registered target is what this cycle's slew sees, so a command landing
    // on a PWM_synch cycle only steers the following period.
    if (cmd_vld && cmd_rdy) target_d = clamp_duty(cmd_spd);

    // Over-current is judged per PWM period: any unblanked hit in the period
    // counts once, at the period boundary.
    if (state_q == S_RUN || state_q == S_RAMP_DN) begin
      if (PWM_synch) begin
        oc_seen_d   = 1'b0;
        fault_cnt_d = oc_per ? cnt_inc : 3'd0;
        trip        = oc_per && (cnt_inc == FAULT_LIMIT);
      end else begin
        oc_seen_d   = oc_seen_q || oc_now;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        duty_d = MID_DUTY;
        if (en && PWM_synch) state_d = S_RUN;
      end
      S_RUN: begin
        if (PWM_synch) duty_d = slew_toward(duty_q, target_q);
        if (trip)      state_d = S_FAULT;
        else if (!en)  state_d = S_RAMP_DN;
      end
      S_RAMP_DN: begin
        if (PWM_synch)               duty_d  = slew_toward(duty_q, MID_DUTY);
        if (trip)                    state_d = S_FAULT;
        else if (en)                 state_d = S_RUN;
        else if (duty_q == MID_DUTY) state_d = S_IDLE;
      end
      S_FAULT: begin
        duty_d = MID_DUTY;
        if (clr_fault && !en) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entering FAULT parks the bridge immediately, bypassing the slew limit.
    if (state_d == S_FAULT) begin
      duty_d  = MID_DUTY;
      fault_d = 1'b1;
    end

    if (state_d == S_IDLE || state_d == S_FAULT) begin
      fault_cnt_d = 3'd0;
      oc_seen_d   = 1'b0;
    end

    // Computed from next-state values so at_tgt lines up with duty.
    at_tgt_d = (state_d == S_RUN) && (duty_d == target_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      duty_q      <= MID_DUTY;
      target_q    <= MID_DUTY;
      fault_q     <= 1'b0;
      fault_cnt_q <= 3'd0;
      oc_seen_q   <= 1'b0;
      at_tgt_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      fault_q     <= fault_d;
      fault_cnt_q <= fault_cnt_d;
      oc_seen_q   <= oc_seen_d;
      at_tgt_q    <= at_tgt_d;
    end
  end

  assign duty   = duty_q;
  assign fault  = fault_q;
  assign at_tgt = at_tgt_q;

endmodule
